core_run_controller: RTL and testbench

//  Sequences the single-cycle RV32I core: loads a program image into instruction memory,

---
 rtl/core_run_controller.sv | 209 ++++++++++++++++++++
 tb/tb_core_run_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_controller.sv
// ============================================================================
// core_run_controller
// ----------------------------------------------------------------------------
// Sequences the single-cycle RV32I core. It loads a program image from a
// host/loader stream into instruction memory and holds the core in reset while
// loading. It then runs, halts or single-steps the core.
//
// Parameters
//   ADDR_W      imem word-address width (capacity 2**ADDR_W words)
//   RST_CYCLES  cycles o_core_rst_n is held low in RSTC before RUN (>=1)
//
// Optional feature (compile-time macro)
//   CORE_RUN_CTRL_BREAKPOINT_EN : PC breakpoint halts the core before the
//                                 breakpoint instruction executes.
//   Without the macro, i_bp_valid / i_bp_addr / i_pc are ignored and o_bp_hit
//   is tied to 0.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_load_start          begin a new program load
//   i_load_valid          loader handshake, together with o_load_ready
//   o_load_ready          accepts words; high in LOAD only
//   i_load_data           program word
//   i_load_last           marks the final word of the image
//   o_imem_we / o_imem_waddr / o_imem_wdata
//                         registered imem write port, one cycle after transfer
//   i_run_req, i_halt_req, i_step_req
//                         run / halt / single-step control
//   i_pc, i_bp_valid, i_bp_addr
//                         breakpoint compare inputs
//   o_core_rst_n          active-low core reset
//   o_core_clk_en         core advance enable
//   o_state               IDLE=0 LOAD=1 RSTC=2 RUN=3 HALT=4 STEP=5
//   o_word_count          words written in the current or last load
//   o_load_err            sticky flag: the image overflowed imem
//   o_bp_hit              sticky flag: the core halted on a breakpoint
// ============================================================================
module core_run_controller #(
    parameter int ADDR_W     = 10,
    parameter int RST_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [31:0]       i_load_data,
    input  logic              i_load_last,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_waddr,
    output logic [31:0]       o_imem_wdata,
    input  logic              i_run_req,
    input  logic              i_halt_req,
    input  logic              i_step_req,
    input  logic [31:0]       i_pc,
    input  logic              i_bp_valid,
    input  logic [31:0]       i_bp_addr,
    output logic              o_core_rst_n,
    output logic              o_core_clk_en,
    output logic [2:0]        o_state,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_load_err,
    output logic              o_bp_hit
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RSTC = 3'd2,
        S_RUN  = 3'd3,
        S_HALT = 3'd4,
        S_STEP = 3'd5
    } state_t;

    localparam int              CW      = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_END = CW'(RST_CYCLES - 1);
    // Full imem: word_count equal to this value means there is no room left.
    localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state, w_next;
    logic [CW-1:0]       r_rst_cnt;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_waddr;
    logic [31:0]         r_imem_wdata;
    logic [ADDR_W:0]     r_word_count;
    logic                r_load_err;
    logic                w_xfer;
    logic                w_enter_load;
    logic                w_bp_stop;

    assign w_xfer       = (r_state == S_LOAD) && i_load_valid;
    assign w_enter_load = (r_state != S_LOAD) && (w_next == S_LOAD);

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    logic r_bp_mask;
    logic r_bp_hit;
    logic w_resume;

    assign w_resume  = (r_state == S_HALT) && (w_next == S_RUN);
    // The first RUN cycle after a resume masks the compare. This lets the core
    // execute the instruction it stopped on instead of re-hitting it.
    assign w_bp_stop = (r_state == S_RUN) && i_bp_valid &&
                       (i_pc == i_bp_addr) && !r_bp_mask;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bp_mask <= 1'b0;
            r_bp_hit  <= 1'b0;
        end else begin
            r_bp_mask <= w_resume;
            if (w_resume)
                r_bp_hit <= 1'b0;
            else if (w_bp_stop && (w_next == S_HALT))
                r_bp_hit <= 1'b1;
        end
    end

    assign o_bp_hit = r_bp_hit;
`else
    logic w_bp_unused;
    assign w_bp_unused = ^{i_bp_valid, i_bp_addr, i_pc};
    assign w_bp_stop   = 1'b0;
    assign o_bp_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_load_start)   w_next = S_LOAD;
                else if (i_run_req) w_next = S_RSTC;
            end
            S_LOAD: begin
                if (w_xfer && i_load_last) w_next = S_RSTC;
            end
            S_RSTC: begin
                if (r_rst_cnt == CNT_END) w_next = S_RUN;
            end
            S_RUN: begin
                if (i_load_start)    w_next = S_LOAD;
                else if (w_bp_stop)  w_next = S_HALT;
                else if (i_halt_req) w_next = S_HALT;
            end
            S_HALT: begin
                if (i_load_start)    w_next = S_LOAD;
                else if (i_run_req)  w_next = S_RUN;
                else if (i_step_req) w_next = S_STEP;
            end
            S_STEP:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore outputs. The breakpoint gate is the only input-dependent term.
    // It stops the breakpoint instruction within the same cycle.
    assign o_core_rst_n  = (r_state == S_RUN) || (r_state == S_HALT) || (r_state == S_STEP);
    assign o_load_ready  = (r_state == S_LOAD);
    assign o_core_clk_en = ((r_state == S_RUN) && !w_bp_stop) || (r_state == S_STEP);
    assign o_state       = r_state;

    // Reset-hold counter. It is held at zero outside RSTC, so every entry
    // starts a fresh count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                 r_rst_cnt <= '0;
        else if (r_state == S_RSTC) r_rst_cnt <= r_rst_cnt + 1'b1;
        else                        r_rst_cnt <= '0;
    end

    // Load datapath. A word that arrives once imem is full is accepted to keep
    // the stream moving, but it is dropped and flagged.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_word_count <= '0;
            r_load_err   <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_enter_load) begin
                r_word_count <= '0;
                r_load_err   <= 1'b0;
            end else if (w_xfer) begin
                if (r_word_count == CAP) begin
                    r_load_err <= 1'b1;
                end else begin
                    r_imem_we    <= 1'b1;
                    r_imem_waddr <= r_word_count[ADDR_W-1:0];
                    r_imem_wdata <= i_load_data;
                    r_word_count <= r_word_count + 1'b1;
                end
            end
        end
    end

    assign o_imem_we    = r_imem_we;
    assign o_imem_waddr = r_imem_waddr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_word_count = r_word_count;
    assign o_load_err   = r_load_err;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller. Two instances share all stimulus:
// instance A uses ADDR_W=10, and instance B uses ADDR_W=2 (4-word imem) to
// exercise overflow.
module tb_core_run_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [31:0] load_data = '0;
    logic        run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
    logic [31:0] pc = '0, bp_addr = '0;
    logic        bp_valid = 1'b0;

    logic        a_ready, a_we, a_rst_n, a_en, a_err, a_bp;
    logic [9:0]  a_waddr;
    logic [31:0] a_wdata;
    logic [2:0]  a_state;
    logic [10:0] a_cnt;

    logic        b_ready, b_we, b_rst_n, b_en, b_err, b_bp;
    logic [1:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [2:0]  b_state;
    logic [2:0]  b_cnt;

    core_run_controller #(.ADDR_W(10), .RST_CYCLES(4)) u_a (
        .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_load_valid(load_valid),
        .o_load_ready(a_ready), .i_load_data(load_data), .i_load_last(load_last),
        .o_imem_we(a_we), .o_imem_waddr(a_waddr), .o_imem_wdata(a_wdata),
        .i_run_req(run_req), .i_halt_req(halt_req), .i_step_req(step_req),
        .i_pc(pc), .i_bp_valid(bp_valid), .i_bp_addr(bp_addr),
        .o_core_rst_n(a_rst_n), .o_core_clk_en(a_en), .o_state(a_state),
        .o_word_count(a_cnt), .o_load_err(a_err), .o_bp_hit(a_bp));

    core_run_controller #(.ADDR_W(2), .RST_CYCLES(4)) u_b (
        .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_load_valid(load_valid),
        .o_load_ready(b_ready), .i_load_data(load_data), .i_load_last(load_last),
        .o_imem_we(b_we), .o_imem_waddr(b_waddr), .o_imem_wdata(b_wdata),
        .i_run_req(run_req), .i_halt_req(halt_req), .i_step_req(step_req),
        .i_pc(pc), .i_bp_valid(bp_valid), .i_bp_addr(bp_addr),
        .o_core_rst_n(b_rst_n), .o_core_clk_en(b_en), .o_state(b_state),
        .o_word_count(b_cnt), .o_load_err(b_err), .o_bp_hit(b_bp));

    always #5 clk = ~clk;

    // Write logs, sampled on the inactive edge.
    logic [31:0] a_log_addr[$], a_log_data[$], b_log_addr[$], b_log_data[$];
    always @(negedge clk) begin
        if (a_we) begin a_log_addr.push_back(32'(a_waddr)); a_log_data.push_back(a_wdata); end
        if (b_we) begin b_log_addr.push_back(32'(b_waddr)); b_log_data.push_back(b_wdata); end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        a_log_addr.delete(); a_log_data.delete();
        b_log_addr.delete(); b_log_data.delete();
    endtask

    task automatic xfer(input logic [31:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    function automatic logic [31:0] a_at(input int i, input bit data);
        if (i >= a_log_addr.size()) return 32'hDEAD_BEEF;
        return data ? a_log_data[i] : a_log_addr[i];
    endfunction

    function automatic logic [31:0] b_at(input int i, input bit data);
        if (i >= b_log_addr.size()) return 32'hDEAD_BEEF;
        return data ? b_log_data[i] : b_log_addr[i];
    endfunction

    // Steps through RSTC and checks that the core stays in reset for exactly
    // four cycles before RUN.
    task automatic rstc_to_run(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_rstc_state"}, 32'(a_state), 32'd2);
            check({tag, "_rstc_rstn"},  32'(a_rst_n), 32'd0);
            tick();
        end
        check({tag, "_run_state"}, 32'(a_state), 32'd3);
        check({tag, "_run_rstn"},  32'(a_rst_n), 32'd1);
        check({tag, "_run_en"},    32'(a_en),    32'd1);
    endtask

    logic [31:0] gap_data[4];
    logic        gap_vld[7];

    initial begin
        // ---- reset state
        tick(); tick();
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_outs",  {a_rst_n, a_en, a_ready, a_we, a_err, a_bp}, 32'd0);
        check("rst_addr",  32'(a_waddr), 32'd0);
        check("rst_wdata", a_wdata,      32'd0);
        check("rst_cnt",   32'(a_cnt),   32'd0);
        rst = 1'b1;
        tick();
        check("idle_hold", 32'(a_state), 32'd0);

        // ---- IDLE run_req without a load goes through RSTC to RUN
        run_req = 1'b1; tick(); run_req = 1'b0;
        rstc_to_run("idle_run");

        // ---- 3-word load A,B,C started from RUN
        clear_logs();
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("ld3_state", 32'(a_state), 32'd1);
        check("ld3_ready", 32'(a_ready), 32'd1);
        check("ld3_rstn",  32'(a_rst_n), 32'd0);
        xfer(32'hAAAA_0001, 1'b0);
        xfer(32'hBBBB_0002, 1'b0);
        xfer(32'hCCCC_0003, 1'b1);
        check("ld3_cnt", 32'(a_cnt), 32'd3);
        rstc_to_run("ld3");
        check("ld3_nwr", 32'(a_log_addr.size()), 32'd3);
        check("ld3_a0", a_at(0, 0), 32'd0); check("ld3_d0", a_at(0, 1), 32'hAAAA_0001);
        check("ld3_a1", a_at(1, 0), 32'd1); check("ld3_d1", a_at(1, 1), 32'hBBBB_0002);
        check("ld3_a2", a_at(2, 0), 32'd2); check("ld3_d2", a_at(2, 1), 32'hCCCC_0003);

        // ---- halt: the sampling cycle still enables, the next cycle does not
        halt_req = 1'b1;
        check("halt_en_same", 32'(a_en), 32'd1);
        tick(); halt_req = 1'b0;
        check("halt_state", 32'(a_state), 32'd4);
        check("halt_en",    32'(a_en),    32'd0);
        check("halt_rstn",  32'(a_rst_n), 32'd1);

        // ---- single step; run_req during STEP is ignored
        step_req = 1'b1; tick(); step_req = 1'b0;
        check("step_state", 32'(a_state), 32'd5);
        check("step_en",    32'(a_en),    32'd1);
        run_req = 1'b1; tick(); run_req = 1'b0;
        check("step_back", 32'(a_state), 32'd4);
        check("step_off",  32'(a_en),    32'd0);

        // ---- resume
        run_req = 1'b1; tick(); run_req = 1'b0;
        check("resume_state", 32'(a_state), 32'd3);

        // ---- breakpoint at 0x8
        pc = 32'h4; bp_addr = 32'h8; bp_valid = 1'b1;
        tick();
        pc = 32'h8;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
        check("bp_en_gate", 32'(a_en), 32'd0);
        tick();
        check("bp_state", 32'(a_state), 32'd4);
        check("bp_hit",   32'(a_bp),    32'd1);
        run_req = 1'b1; tick(); run_req = 1'b0;
        check("bp_resume_en",  32'(a_en), 32'd1);
        check("bp_hit_clear",  32'(a_bp), 32'd0);
        pc = 32'hC; tick();
        check("bp_continue", 32'(a_state), 32'd3);
`else
        check("nobp_en", 32'(a_en), 32'd1);
        tick();
        check("nobp_state", 32'(a_state), 32'd3);
        check("nobp_hit",   32'(a_bp),    32'd0);
`endif
        bp_valid = 1'b0;

        // ---- load with gaps in load_valid; writes must be contiguous
        clear_logs();
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("gap_cnt_clr", 32'(a_cnt),   32'd0);
        check("gap_rstn",    32'(a_rst_n), 32'd0);
        gap_vld = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        begin
            int k = 0;
            for (int i = 0; i < 7; i++) begin
                load_valid = gap_vld[i];
                load_data  = 32'h100 + 32'(i);
                load_last  = (i == 6);
                if (gap_vld[i]) begin gap_data[k] = 32'h100 + 32'(i); k++; end
                tick();
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("gap_cnt",   32'(a_cnt),   32'd4);
        check("gap_state", 32'(a_state), 32'd2);
        check("gap_berr",  32'(b_err),   32'd0);
        rstc_to_run("gap");
        check("gap_nwr", 32'(a_log_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("gap_a%0d", i), a_at(i, 0), 32'(i));
            check($sformatf("gap_d%0d", i), a_at(i, 1), gap_data[i]);
        end

        // ---- overflow: 5 words into a 4-word imem (instance B)
        clear_logs();
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 5; i++) xfer(32'h200 + 32'(i), i == 4);
        check("ovf_bstate", 32'(b_state), 32'd2);
        check("ovf_berr",   32'(b_err),   32'd1);
        check("ovf_bcnt",   32'(b_cnt),   32'd4);
        check("ovf_acnt",   32'(a_cnt),   32'd5);
        check("ovf_aerr",   32'(a_err),   32'd0);
        rstc_to_run("ovf");
        check("ovf_bnwr", 32'(b_log_addr.size()), 32'd4);
        check("ovf_anwr", 32'(a_log_addr.size()), 32'd5);
        check("ovf_b3a",  b_at(3, 0), 32'd3);
        check("ovf_b3d",  b_at(3, 1), 32'h203);
        check("ovf_berr_hold", 32'(b_err), 32'd1);

        // ---- reset in the middle of a load
        load_start = 1'b1; tick(); load_start = 1'b0;
        xfer(32'h300, 1'b0);
        xfer(32'h301, 1'b0);
        check("mid_we_pre", 32'(a_we), 32'd1);
        rst = 1'b0; #1;
        check("mid_state", 32'(a_state), 32'd0);
        check("mid_outs",  {a_rst_n, a_en, a_ready, a_we, a_err, a_bp}, 32'd0);
        check("mid_addr",  32'(a_waddr), 32'd0);
        check("mid_wdata", a_wdata,      32'd0);
        check("mid_cnt",   32'(a_cnt),   32'd0);
        check("mid_berr",  32'(b_err),   32'd0);
        tick();
        rst = 1'b1;
        tick();
        clear_logs();
        load_start = 1'b1; tick(); load_start = 1'b0;
        xfer(32'h400, 1'b1);
        tick();
        check("reload_nwr",  32'(a_log_addr.size()), 32'd1);
        check("reload_addr", a_at(0, 0), 32'd0);
        check("reload_data", a_at(0, 1), 32'h400);
        check("reload_cnt",  32'(a_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
